lsu: RTL and testbench
======================

# lsu

Load/store unit that sits between the CPU datapath and the `dmem` data RAM and drives its `re`/`we`/`addr`/`wdata` port. It accepts one byte, halfword or word access per handshake from the core. Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended. Misaligned accesses are rejected without touching memory.

## Interface
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `BUS_WIDTH`, 6, width of the word index into dmem; the byte address is `BUS_WIDTH+2` bits.
- `clk` input 1: single clock; all state changes on posedge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req_valid` input 1: core request valid.
- `req_ready` output 1: unit can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- `req_unsigned` input 1: zero-extend load data; ignored for stores.
- `req_addr` input `BUS_WIDTH+2`: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: response available.
- `resp_ready` input 1: core accepts the response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned or illegal-size request.
- `mem_re` output 1: dmem read enable.
- `mem_we` output 1: dmem write enable.
- `mem_addr` output `BUS_WIDTH`: dmem word index, equal to `req_addr[BUS_WIDTH+1:2]`.
- `mem_wdata` output 32: dmem write data.
- `mem_rdata` input 32: dmem read data, combinational from `mem_addr` while `mem_re` = 1.

## Operation
- **FSM states:** IDLE, RD, WR, RESP.
- **Byte lanes:** little-endian; byte offset k = `addr[1:0]` occupies bits [8k+7:8k].
- **Legality:**
  - Error if size = 3.
  - Error if a halfword has `addr[0]` = 1.
  - Error if a word has `addr[1:0]` ≠ 0.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, capture `we`, `size`, `unsigned`, `addr` and `wdata`.
  - Illegal request → RESP with `resp_err` = 1.
  - Load → RD.
  - Word store → WR, with `mem_wdata` = `req_wdata`.
  - Byte or halfword store → RD.
- **RD:**
  - `mem_re` = 1 and `mem_addr` = captured word index.
  - At the clock edge, sample `mem_rdata`.
  - Load: extract the addressed byte or half, sign- or zero-extend it into `resp_rdata`, → RESP.
  - Sub-word store: merge the store data into the selected lanes of the sampled word into `mem_wdata`, keep the other lanes, → WR.
- **WR:** `mem_we` = 1 for exactly one cycle (dmem commits at this edge), → RESP with `resp_rdata` = 0.
- **RESP:**
  - `resp_valid` = 1; `resp_rdata` and `resp_err` are held stable.
  - When `resp_ready` = 1 → IDLE and clear `resp_valid`.
- **Exclusivity:**
  - `mem_re` and `mem_we` are never both 1.
  - Both are 0 in IDLE and RESP.
  - `req_ready` = 0 in every state except IDLE.
- **Reset:**
  - `rst_n` = 0 at a posedge forces IDLE, aborting any access, including one in WR (no write is issued at that edge).
  - All outputs reset to 0 except `req_ready`, which is 1 from the first cycle after reset.
  - `mem_addr`, `mem_wdata`, `resp_rdata` and `resp_err` reset to 0.

## Timing
- A request is accepted at edge E0.
- **Load:** RD in cycle E0..E1; `resp_valid` from E1.
- **Word store:** WR in E0..E1; RAM updated at E1; `resp_valid` from E1.
- **Sub-word store:** RD in E0..E1, WR in E1..E2; RAM updated at E2; `resp_valid` from E2.
- **Error:** `resp_valid` from E1; no memory enable is asserted.
- **Throughput:** the next request is accepted no earlier than the edge after the response handshake. `resp_ready` held at 1 gives a load rate of one per 3 cycles.
- **Stability:** `mem_addr` and `mem_wdata` are stable for the whole RD/WR cycle, so dmem's combinational read is valid before the edge.

## Test plan
- **Word store then load:** store word addr 0x08, data 0xDEADBEEF → one cycle of `mem_we` with `mem_addr` = 2 and `mem_wdata` = 0xDEADBEEF. Then load word 0x08 → `resp_rdata` = 0xDEADBEEF, `resp_err` = 0.
- **Byte load extension:** with word 2 = 0xDEADBEEF, load byte 0x09 signed → 0xFFFFFFBE; unsigned → 0x000000BE. Load half 0x0A signed → 0xFFFFDEAD.
- **Sub-word store RMW:** store byte 0x0B, data 0x12 → RD then WR with `mem_wdata` = 0x12ADBEEF. Store half 0x08, data 0x5678 → word becomes 0x12AD5678.
- **Misaligned requests:** word at 0x05, half at 0x03 and size 3 → each gives `resp_valid` one cycle after accept with `resp_err` = 1, `resp_rdata` = 0, and `mem_re` = `mem_we` = 0 throughout.
- **Backpressure:** hold `resp_ready` = 0 for 5 cycles after a load → `resp_valid` and `resp_rdata` stay stable, `req_ready` = 0, and a second `req_valid` is not accepted until one cycle after the handshake.
- **Reset mid-operation:** assert `rst_n` = 0 during RD of a byte store → no `mem_we` pulse, RAM unchanged, all outputs 0 and `req_ready` = 1 after reset.

Source files
------------

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit between the core and a word-wide data RAM.
//             Byte/halfword/word accesses, read-modify-write for sub-word
//             stores, sign/zero-extended loads, misaligned requests rejected.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [BUS_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   resp_err,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [BUS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Captured request attributes
  logic                  op_we;
  logic [1:0]            op_size;
  logic                  op_unsigned;
  logic [1:0]            op_off;
  logic [DATA_WIDTH-1:0] op_wdata;

  logic                  req_illegal;
  logic [4:0]            lane_shift;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] extended;

  // Legality of the incoming request: bad size or misaligned half/word
  always_comb begin
    req_illegal = 1'b0;
    case (req_size)
      2'd1:    req_illegal = req_addr[0];
      2'd2:    req_illegal = (req_addr[1:0] != 2'b00);
      2'd3:    req_illegal = 1'b1;
      default: req_illegal = 1'b0;
    endcase
  end

  // Lane steering: merge store data into the read word, extract load data
  always_comb begin
    lane_shift = {op_off, 3'b000};
    lane_mask  = (op_size == 2'd0) ? (32'h0000_00FF << lane_shift)
                                   : (32'h0000_FFFF << lane_shift);
    merged     = (mem_rdata & ~lane_mask) | ((op_wdata << lane_shift) & lane_mask);
    shifted    = mem_rdata >> lane_shift;
    case (op_size)
      2'd0:    extended = {{24{~op_unsigned & shifted[7]}}, shifted[7:0]};
      2'd1:    extended = {{16{~op_unsigned & shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded handshake/enable outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_illegal)                        state_nxt = RESP;
          else if (req_we && (req_size == 2'd2))  state_nxt = WR;
          else                                    state_nxt = RD;
        end
      end
      RD: begin
        mem_re    = 1'b1;
        state_nxt = op_we ? WR : RESP;
      end
      WR: begin
        // A reset arriving at this edge must not let the write commit
        mem_we    = rst_n;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: request capture, RMW merge, load extension, response hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_we       <= 1'b0;
      op_size     <= 2'd0;
      op_unsigned <= 1'b0;
      op_off      <= 2'd0;
      op_wdata    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_we       <= req_we;
            op_size     <= req_size;
            op_unsigned <= req_unsigned;
            op_off      <= req_addr[1:0];
            op_wdata    <= req_wdata;
            mem_addr    <= req_addr[BUS_WIDTH+1:2];
            resp_rdata  <= '0;
            resp_err    <= req_illegal;
            if (!req_illegal && req_we && (req_size == 2'd2))
              mem_wdata <= req_wdata;
          end
        end
        RD: begin
          if (op_we) mem_wdata  <= merged;
          else       resp_rdata <= extended;
        end
        WR:      resp_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu: directed scenarios followed by
//             random traffic compared against a byte-lane memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
  localparam int DW    = 32;
  localparam int BW    = 6;
  localparam int AW    = BW + 2;
  localparam int DEPTH = 1 << BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_re;
  logic          mem_we;
  logic [BW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data RAM attached to the unit: combinational read, write at posedge
  logic [DW-1:0] dmem [DEPTH];
  logic          mem_clear;
  assign mem_rdata = mem_re ? dmem[mem_addr] : '0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
    end
  end

  // Mid-cycle monitor of memory enables and write traffic
  int            re_total = 0;
  int            we_total = 0;
  int            both_total = 0;
  logic [BW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;

  always @(negedge clk) begin
    if (mem_re) re_total <= re_total + 1;
    if (mem_we) begin
      we_total   <= we_total + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_re && mem_we) both_total <= both_total + 1;
  end

  // Reference memory image
  logic [DW-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model of one request: result, latency and RAM effect
  task automatic model(input bit we, input bit [1:0] size, input bit uns,
                       input bit [AW-1:0] addr, input bit [31:0] wdata,
                       output bit err, output bit [31:0] rdata, output int lat,
                       output int exp_re, output int exp_we);
    int        idx;
    int        off;
    bit [31:0] w;
    bit [7:0]  b;
    bit [15:0] h;
    idx    = int'(addr[AW-1:2]);
    off    = int'(addr[1:0]);
    err    = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
             (size == 2'd2 && addr[1:0] != 2'b00);
    rdata  = 32'h0;
    lat    = 1;
    exp_re = 0;
    exp_we = 0;
    if (!err) begin
      w = ref_mem[idx];
      if (!we) begin
        exp_re = 1;
        case (size)
          2'd0: begin
            b     = w[8*off +: 8];
            rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
          end
          2'd1: begin
            h     = w[8*off +: 16];
            rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
          end
          default: rdata = w;
        endcase
      end else begin
        exp_we = 1;
        case (size)
          2'd0:    w[8*off +: 8]  = wdata[7:0];
          2'd1:    w[8*off +: 16] = wdata[15:0];
          default: w = wdata;
        endcase
        if (size != 2'd2) begin
          exp_re = 1;
          lat    = 2;
        end
        ref_mem[idx] = w;
      end
    end
  endtask

  // Issue one request, optionally stall the response, and check everything
  task automatic do_txn(input bit we, input bit [1:0] size, input bit uns,
                        input bit [AW-1:0] addr, input bit [31:0] wdata,
                        input int bp, output bit [31:0] got);
    bit        exp_err;
    bit [31:0] exp_rd;
    int        exp_lat, exp_re, exp_we;
    int        lat, re0, we0, both0, idx;
    bit [31:0] held;
    idx = int'(addr[AW-1:2]);
    model(we, size, uns, addr, wdata, exp_err, exp_rd, exp_lat, exp_re, exp_we);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    re0       = re_total;
    we0       = we_total;
    both0     = both_total;
    req_valid = 1'b0;
    lat       = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 8);
    check("latency", lat, exp_lat);
    held = resp_rdata;
    for (int i = 0; i < bp; i++) begin
      // A store presented while busy must be ignored entirely
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, held);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    got        = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
    check("re_count", re_total - re0, exp_re);
    check("we_count", we_total - we0, exp_we);
    check("re_we_both", both_total - both0, 0);
    if (exp_we != 0) begin
      check("wr_addr", 32'(last_waddr), idx);
      check("wr_data", last_wdata, ref_mem[idx]);
    end
  endtask

  // Check that every output sits at its reset value
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_mem_en"}, 32'({mem_re, mem_we}), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
  endtask

  // Start a request, then reset while it is in flight
  task automatic reset_mid_op(input string tag, input bit [1:0] size,
                              input bit [AW-1:0] addr, input bit [31:0] wdata);
    int we0;
    int idx;
    idx = int'(addr[AW-1:2]);
    @(negedge clk);
    req_we       = 1'b1;
    req_size     = size;
    req_unsigned = 1'b0;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    we0       = we_total;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_no_write"}, we_total - we0, 0);
    check({tag, "_ram"}, dmem[idx], ref_mem[idx]);
    check_reset_outputs(tag);
  endtask

  bit [31:0] got;
  int        mism;

  initial begin
    rst_n        = 1'b0;
    mem_clear    = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");

    // Word store then load
    do_txn(1'b1, 2'd2, 1'b0, 8'h08, 32'hDEADBEEF, 0, got);
    check("tp_sw_addr", 32'(last_waddr), 32'd2);
    check("tp_sw_data", last_wdata, 32'hDEADBEEF);
    do_txn(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, 0, got);
    check("tp_lw", got, 32'hDEADBEEF);

    // Load extension
    do_txn(1'b0, 2'd0, 1'b0, 8'h09, 32'h0, 0, got);
    check("tp_lb", got, 32'hFFFFFFBE);
    do_txn(1'b0, 2'd0, 1'b1, 8'h09, 32'h0, 0, got);
    check("tp_lbu", got, 32'h000000BE);
    do_txn(1'b0, 2'd1, 1'b0, 8'h0A, 32'h0, 0, got);
    check("tp_lh", got, 32'hFFFFDEAD);

    // Sub-word read-modify-write
    do_txn(1'b1, 2'd0, 1'b0, 8'h0B, 32'h00000012, 0, got);
    check("tp_sb_data", last_wdata, 32'h12ADBEEF);
    do_txn(1'b1, 2'd1, 1'b0, 8'h08, 32'h00005678, 0, got);
    do_txn(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, 0, got);
    check("tp_sh_word", got, 32'h12AD5678);

    // Misaligned and illegal-size requests
    do_txn(1'b0, 2'd2, 1'b0, 8'h05, 32'h0, 0, got);
    do_txn(1'b1, 2'd1, 1'b0, 8'h03, 32'hFFFFFFFF, 0, got);
    do_txn(1'b0, 2'd3, 1'b0, 8'h00, 32'h0, 0, got);
    do_txn(1'b1, 2'd2, 1'b0, 8'h0A, 32'h11111111, 0, got);

    // Backpressure on a load response
    do_txn(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, 5, got);
    check("tp_bp_load", got, 32'h12AD5678);

    // Reset during the read phase of a byte store, then during a word write
    reset_mid_op("rst_rd", 2'd0, 8'h08, 32'h000000AA);
    reset_mid_op("rst_wr", 2'd2, 8'h08, 32'h55555555);
    do_txn(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, 0, got);
    check("rst_word_kept", got, 32'h12AD5678);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), AW'($urandom), $urandom,
             int'($urandom_range(0, 2)), got);
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dmem[i] !== ref_mem[i]) mism++;
    check("mem_image", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
